// File: rtl/ex_pkg.sv
// Shared types for the ID/EX operand stage: source-select encodings and the
// decoded instruction bundle held between decode and the ALU.
package ex_pkg;

    localparam int EX_DATA_W     = 64;
    localparam int EX_REG_ADDR_W = 5;

    // Encoding 2'd3 is not named; the stage treats it the same as SRC_A_ZERO.
    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } src_a_sel_e;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_sel_e;

    // Source selects are kept as raw bits so an unnamed encoding survives storage.
    typedef struct packed {
        logic [EX_REG_ADDR_W-1:0] rs1_addr;
        logic [EX_REG_ADDR_W-1:0] rs2_addr;
        logic [EX_REG_ADDR_W-1:0] rd_addr;
        logic [EX_DATA_W-1:0]     rs1_data;
        logic [EX_DATA_W-1:0]     rs2_data;
        logic [EX_DATA_W-1:0]     imm;
        logic [EX_DATA_W-1:0]     pc;
        logic [1:0]               src_a_sel;
        logic                     src_b_sel;
        logic [2:0]               alu_op_select;
        logic                     alu_modifier;
        logic                     reg_write;
    } id_ex_bundle_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand RAW bypass: picks the youngest in-flight producer of rs_addr,
// falling back to the register-file value. x0 never forwards and reads 0.
module fwd_mux #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic                  exm_valid,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [DATA_WIDTH-1:0] exm_data,
    input  logic                  mwb_valid,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [DATA_WIDTH-1:0] mwb_data,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  exm_hit,
    output logic                  mwb_hit
);

    logic rs_nonzero_s;

    assign rs_nonzero_s = (rs_addr != {REG_ADDR_W{1'b0}});
    assign exm_hit = rs_nonzero_s && exm_valid && exm_reg_write && (exm_rd == rs_addr);
    assign mwb_hit = rs_nonzero_s && mwb_valid && mwb_reg_write && (mwb_rd == rs_addr);

    // EX/MEM is younger than MEM/WB, so it wins when both match.
    always_comb begin
        fwd_data = rs_data;
        if (!rs_nonzero_s) begin
            fwd_data = {DATA_WIDTH{1'b0}};
        end else if (exm_hit) begin
            fwd_data = exm_data;
        end else if (mwb_hit) begin
            fwd_data = mwb_data;
        end else begin
            fwd_data = rs_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: holds one decoded bundle, bypasses
// EX/MEM and MEM/WB results, stalls on load-use, and selects ALU operands.
// Widths of the stored bundle come from ex_pkg; the parameters must match it.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = EX_DATA_W,
    parameter int REG_ADDR_W = EX_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [1:0]            in_src_a_sel,
    input  logic                  in_src_b_sel,
    input  logic [2:0]            in_alu_op_select,
    input  logic                  in_alu_modifier,
    input  logic                  in_reg_write,
    input  logic                  exm_valid,
    input  logic                  exm_reg_write,
    input  logic                  exm_is_load,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [DATA_WIDTH-1:0] exm_data,
    input  logic                  mwb_valid,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [DATA_WIDTH-1:0] mwb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic [2:0]            alu_op_select,
    output logic                  alu_modifier,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic [DATA_WIDTH-1:0] out_rs2_fwd
);

    id_ex_bundle_t             entry_r;
    id_ex_bundle_t             in_bundle_s;
    logic                      full_r;
    logic [DATA_WIDTH-1:0]     fwd_rs1_s;
    logic [DATA_WIDTH-1:0]     fwd_rs2_s;
    logic                      rs1_exm_hit_s;
    logic                      rs1_mwb_hit_s;
    logic                      rs2_exm_hit_s;
    logic                      rs2_mwb_hit_s;
    logic                      load_hazard_s;
    logic                      fire_in_s;
    logic                      fire_out_s;

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr(entry_r.rs1_addr), .rs_data(entry_r.rs1_data),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_valid(mwb_valid), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_data(fwd_rs1_s), .exm_hit(rs1_exm_hit_s), .mwb_hit(rs1_mwb_hit_s)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr(entry_r.rs2_addr), .rs_data(entry_r.rs2_data),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_valid(mwb_valid), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .fwd_data(fwd_rs2_s), .exm_hit(rs2_exm_hit_s), .mwb_hit(rs2_mwb_hit_s)
    );

    // rs2 always counts as used because stores carry it even when B selects IMM.
    assign load_hazard_s = full_r && exm_is_load &&
                           (((entry_r.src_a_sel == SRC_A_RS1) && rs1_exm_hit_s) || rs2_exm_hit_s);
    assign out_valid  = full_r && !load_hazard_s;
    assign fire_out_s = out_valid && out_ready;
    assign in_ready   = !full_r || fire_out_s;
    assign fire_in_s  = in_valid && in_ready;

    // Pack the incoming decode fields into the stored bundle layout.
    always_comb begin
        in_bundle_s               = '{default: 1'b0};
        in_bundle_s.rs1_addr      = in_rs1_addr;
        in_bundle_s.rs2_addr      = in_rs2_addr;
        in_bundle_s.rd_addr       = in_rd_addr;
        in_bundle_s.rs1_data      = in_rs1_data;
        in_bundle_s.rs2_data      = in_rs2_data;
        in_bundle_s.imm           = in_imm;
        in_bundle_s.pc            = in_pc;
        in_bundle_s.src_a_sel     = in_src_a_sel;
        in_bundle_s.src_b_sel     = in_src_b_sel;
        in_bundle_s.alu_op_select = in_alu_op_select;
        in_bundle_s.alu_modifier  = in_alu_modifier;
        in_bundle_s.reg_write     = in_reg_write;
    end

    // Entry update: flush beats load, load beats drain; while held, capture any
    // forwarded value so a producer retiring during the stall is not lost.
    // A non-matching operand already equals its stored value, so only hits write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r  <= 1'b0;
            entry_r <= '{default: 1'b0};
        end else if (flush) begin
            full_r <= 1'b0;
        end else if (fire_in_s) begin
            full_r  <= 1'b1;
            entry_r <= in_bundle_s;
        end else if (fire_out_s) begin
            full_r <= 1'b0;
        end else if (full_r) begin
            if (rs1_exm_hit_s || rs1_mwb_hit_s) begin
                entry_r.rs1_data <= fwd_rs1_s;
            end
            if (rs2_exm_hit_s || rs2_mwb_hit_s) begin
                entry_r.rs2_data <= fwd_rs2_s;
            end
        end
    end

    // ALU A source; the unnamed encoding falls through to zero.
    always_comb begin
        operand_a = {DATA_WIDTH{1'b0}};
        case (entry_r.src_a_sel)
            SRC_A_RS1: operand_a = fwd_rs1_s;
            SRC_A_PC:  operand_a = entry_r.pc;
            default:   operand_a = {DATA_WIDTH{1'b0}};
        endcase
    end

    // ALU B source.
    always_comb begin
        operand_b = fwd_rs2_s;
        if (entry_r.src_b_sel == SRC_B_IMM) begin
            operand_b = entry_r.imm;
        end else begin
            operand_b = fwd_rs2_s;
        end
    end

    assign alu_op_select = entry_r.alu_op_select;
    assign alu_modifier  = entry_r.alu_modifier;
    assign out_rd        = entry_r.rd_addr;
    assign out_reg_write = entry_r.reg_write;
    assign out_rs2_fwd   = fwd_rs2_s;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding, load-use stall,
// refresh while stalled, source selection, flush and streaming throughput.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [63:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic [1:0]  in_src_a_sel;
    logic        in_src_b_sel;
    logic [2:0]  in_alu_op_select;
    logic        in_alu_modifier;
    logic        in_reg_write;
    logic        exm_valid, exm_reg_write, exm_is_load;
    logic [4:0]  exm_rd;
    logic [63:0] exm_data;
    logic        mwb_valid, mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [63:0] mwb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] operand_a, operand_b;
    logic [2:0]  alu_op_select;
    logic        alu_modifier;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [63:0] out_rs2_fwd;

    int n_checks = 0;
    int n_fail   = 0;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
        .in_src_a_sel(in_src_a_sel), .in_src_b_sel(in_src_b_sel),
        .in_alu_op_select(in_alu_op_select), .in_alu_modifier(in_alu_modifier),
        .in_reg_write(in_reg_write),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
        .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_valid(mwb_valid), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_op_select(alu_op_select), .alu_modifier(alu_modifier),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_rs2_fwd(out_rs2_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: summary not reached, got time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [63:0] d1, input logic [63:0] d2,
                              input logic [63:0] imm, input logic [63:0] pc,
                              input logic [1:0] asel, input logic bsel,
                              input logic [2:0] op, input logic modi, input logic rw);
        in_valid = 1'b1;
        in_rs1_addr = rs1; in_rs2_addr = rs2; in_rd_addr = rd;
        in_rs1_data = d1;  in_rs2_data = d2;  in_imm = imm; in_pc = pc;
        in_src_a_sel = asel; in_src_b_sel = bsel;
        in_alu_op_select = op; in_alu_modifier = modi; in_reg_write = rw;
    endtask

    task automatic clear_fwd();
        exm_valid = 1'b0; exm_reg_write = 1'b0; exm_is_load = 1'b0; exm_rd = 5'd0; exm_data = 64'd0;
        mwb_valid = 1'b0; mwb_reg_write = 1'b0; mwb_rd = 5'd0; mwb_data = 64'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0;
        clear_fwd();
        set_bundle(5'd1, 5'd2, 5'd3, 64'd7, 64'd9, 64'd0, 64'd0, 2'd0, 1'b0, 3'd4, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (operand_a !== 64'd0) begin n_fail++; $display("FAIL rst_operand_a: got %h want 0", operand_a); end
        n_checks++; if (operand_b !== 64'd0) begin n_fail++; $display("FAIL rst_operand_b: got %h want 0", operand_b); end
        n_checks++; if (alu_op_select !== 3'd0) begin n_fail++; $display("FAIL rst_alu_op: got %h want 0", alu_op_select); end
        n_checks++; if (alu_modifier !== 1'b0) begin n_fail++; $display("FAIL rst_alu_mod: got %b want 0", alu_modifier); end
        n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL rst_out_rd: got %h want 0", out_rd); end
        n_checks++; if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_reg_write: got %b want 0", out_reg_write); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
        n_checks++; if (operand_a !== 64'd7) begin n_fail++; $display("FAIL first_operand_a: got %h want 7", operand_a); end
        n_checks++; if (operand_b !== 64'd9) begin n_fail++; $display("FAIL first_operand_b: got %h want 9", operand_b); end
        n_checks++; if (alu_op_select !== 3'd4 || alu_modifier !== 1'b1 || out_rd !== 5'd3 || out_reg_write !== 1'b1) begin
            n_fail++; $display("FAIL first_passthru: got op=%h mod=%b rd=%h rw=%b want op=4 mod=1 rd=3 rw=1",
                               alu_op_select, alu_modifier, out_rd, out_reg_write); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_forward_exm();
        set_bundle(5'd5, 5'd6, 5'd7, 64'd10, 64'd20, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd5; exm_data = 64'h100;
        #1;
        n_checks++; if (operand_a !== 64'h100) begin n_fail++; $display("FAIL exm_fwd_a: got %h want 100", operand_a); end
        n_checks++; if (operand_b !== 64'd20) begin n_fail++; $display("FAIL exm_fwd_b: got %h want 14", operand_b); end
        tick();
        clear_fwd();
    endtask

    task automatic test_priority();
        set_bundle(5'd5, 5'd6, 5'd7, 64'd10, 64'd20, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd5; exm_data = 64'h1;
        mwb_valid = 1'b1; mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_data = 64'h2;
        #1;
        n_checks++; if (operand_a !== 64'h1) begin n_fail++; $display("FAIL prio_exm_wins: got %h want 1", operand_a); end
        exm_valid = 1'b0;
        #1;
        n_checks++; if (operand_a !== 64'h2) begin n_fail++; $display("FAIL prio_mwb_only: got %h want 2", operand_a); end
        exm_valid = 1'b1; exm_reg_write = 1'b0;
        #1;
        n_checks++; if (operand_a !== 64'h2) begin n_fail++; $display("FAIL prio_exm_no_write: got %h want 2", operand_a); end
        tick();
        clear_fwd();
        set_bundle(5'd0, 5'd6, 5'd7, 64'h33, 64'h44, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_rd = 5'd0; exm_data = 64'h77;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (operand_a !== 64'd0) begin n_fail++; $display("FAIL x0_reads_zero: got %h want 0", operand_a); end
        n_checks++; if (operand_b !== 64'h44) begin n_fail++; $display("FAIL x0_other_b: got %h want 44", operand_b); end
        tick();
        clear_fwd();
    endtask

    task automatic test_load_hazard();
        set_bundle(5'd5, 5'd6, 5'd7, 64'd10, 64'd20, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        exm_valid = 1'b1; exm_reg_write = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd5; exm_data = 64'hDEAD;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_bubble_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_bubble_ready: got %b want 0", in_ready); end
        tick();
        clear_fwd();
        mwb_valid = 1'b1; mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_data = 64'hAB;
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL load_resume_valid: got %b want 1", out_valid); end
        n_checks++; if (operand_a !== 64'hAB) begin n_fail++; $display("FAIL load_resume_a: got %h want ab", operand_a); end
        tick();
        clear_fwd();
        #1;
        n_checks++; if (operand_a !== 64'hAB) begin n_fail++; $display("FAIL load_retained_a: got %h want ab", operand_a); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_refresh_stall();
        out_ready = 1'b0;
        set_bundle(5'd7, 5'd8, 5'd9, 64'h11, 64'h22, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        mwb_valid = 1'b1; mwb_reg_write = 1'b1; mwb_rd = 5'd7; mwb_data = 64'h55;
        #1;
        n_checks++; if (operand_a !== 64'h55) begin n_fail++; $display("FAIL stall_c1_a: got %h want 55", operand_a); end
        n_checks++; if (operand_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL imm_neg4_b: got %h want fffffffffffffffc", operand_b); end
        n_checks++; if (out_rs2_fwd !== 64'h22) begin n_fail++; $display("FAIL stall_rs2_fwd: got %h want 22", out_rs2_fwd); end
        tick();
        clear_fwd();
        #1;
        n_checks++; if (operand_a !== 64'h55) begin n_fail++; $display("FAIL stall_c2_a: got %h want 55", operand_a); end
        tick();
        n_checks++; if (operand_a !== 64'h55 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_c3: got a=%h v=%b want a=55 v=1", operand_a, out_valid); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_src_sel();
        set_bundle(5'd1, 5'd2, 5'd3, 64'h10, 64'h20, 64'd0, 64'h1000, 2'd1, 1'b0, 3'd5, 1'b0, 1'b0);
        tick();
        set_bundle(5'd1, 5'd2, 5'd4, 64'h10, 64'h20, 64'd0, 64'h2000, 2'd3, 1'b0, 3'd6, 1'b1, 1'b1);
        #1;
        n_checks++; if (operand_a !== 64'h1000) begin n_fail++; $display("FAIL src_a_pc: got %h want 1000", operand_a); end
        n_checks++; if (alu_op_select !== 3'd5 || out_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL pc_passthru: got op=%h rw=%b want op=5 rw=0", alu_op_select, out_reg_write); end
        tick();
        set_bundle(5'd1, 5'd2, 5'd5, 64'h10, 64'h20, 64'd0, 64'h3000, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1);
        #1;
        n_checks++; if (operand_a !== 64'd0) begin n_fail++; $display("FAIL src_a_sel3_zero: got %h want 0", operand_a); end
        n_checks++; if (out_rd !== 5'd4 || alu_modifier !== 1'b1) begin
            n_fail++; $display("FAIL sel3_passthru: got rd=%h mod=%b want rd=4 mod=1", out_rd, alu_modifier); end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (operand_a !== 64'd0 || operand_b !== 64'h20) begin
            n_fail++; $display("FAIL src_a_zero: got a=%h b=%h want a=0 b=20", operand_a, operand_b); end
        tick();
    endtask

    task automatic test_flush();
        set_bundle(5'd1, 5'd2, 5'd3, 64'hA1, 64'd0, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        set_bundle(5'd2, 5'd2, 5'd3, 64'hB2, 64'd0, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_valid: got %b want 1", out_valid); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_still_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_a;
        out_ready = 1'b1;
        set_bundle(5'd1, 5'd2, 5'd3, 64'h10, 64'd0, 64'd0, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_rs1_data = 64'h10 + 64'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_a = 64'h10 + 64'(i);
            n_checks++; if (out_valid !== 1'b1 || operand_a !== exp_a) begin
                n_fail++; $display("FAIL b2b_%0d: got v=%b a=%h want v=1 a=%h", i, out_valid, operand_a, exp_a); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rd_addr = 5'd0;
        in_rs1_data = 64'd0; in_rs2_data = 64'd0; in_imm = 64'd0; in_pc = 64'd0;
        in_src_a_sel = 2'd0; in_src_b_sel = 1'b0; in_alu_op_select = 3'd0;
        in_alu_modifier = 1'b0; in_reg_write = 1'b0;
        clear_fwd();
        test_reset();
        test_forward_exm();
        test_priority();
        test_load_hazard();
        test_refresh_stall();
        test_src_sel();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
